sec_daec_scrub_ctrl: RTL

//  Patrol-scrub sequencer for one ECC-protected memory of 72-bit SEC-DAEC codewords.
//  - Walks addresses 0..DEPTH-1 at a programmed rate.
//  - Reads each word and presents the codeword to an external SEC_DAEC_decoder (combinational).
//  - Writes the corrected 64-bit message back on SE/DAE; the memory write path re-encodes it.
//  - Keeps saturating SE/DAE/UE counters and a sticky uncorrectable-error log.

---
 rtl/sec_daec_scrub_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sec_daec_scrub_ctrl.sv
// Patrol-scrub sequencer for a SEC-DAEC protected memory: walks every word, presents it to an
// external decoder, writes corrected data back and keeps saturating error statistics.
module sec_daec_scrub_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int INTERVAL = 256,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear_ue,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_rvalid,
  input  logic [71:0]       mem_rd_data,
  output logic [71:0]       dec_codeword,
  input  logic [63:0]       dec_message,
  input  logic [1:0]        dec_error_type,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [63:0]       mem_wr_data,
  input  logic              mem_wr_gnt,
  output logic              busy,
  output logic              pass_done,
  output logic [CNT_W-1:0]  se_cnt,
  output logic [CNT_W-1:0]  dae_cnt,
  output logic [CNT_W-1:0]  ue_cnt,
  output logic              ue_flag,
  output logic [ADDR_W-1:0] ue_addr,
  output logic [2:0]        state_dbg
);

  // Handshake: a request rises in its state and stays high with address/data frozen until
  // gnt is seen high at a clock edge; read data is taken only on rvalid while in S_RD_WAIT.

  localparam int                 TIMER_W    = (INTERVAL < 1) ? 1 : $clog2(INTERVAL + 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(INTERVAL);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_DECODE  = 3'd3,
    S_WR_REQ  = 3'd4,
    S_NEXT    = 3'd5,
    S_WAIT    = 3'd6
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [TIMER_W-1:0]  timer;
  logic [71:0]         codeword_q;
  logic [63:0]         wr_data_q;
  logic [CNT_W-1:0]    se_q;
  logic [CNT_W-1:0]    dae_q;
  logic [CNT_W-1:0]    ue_q;
  logic                ue_flag_q;
  logic [ADDR_W-1:0]   ue_addr_q;
  logic                last_addr;
  logic                is_ue;

  assign last_addr = (addr == LAST_ADDR);
  assign is_ue     = (state == S_DECODE) && (dec_error_type == 2'b11);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // en is only honoured where no memory transaction can be left dangling.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (en) state_nxt = S_RD_REQ;
      S_RD_REQ:  if (mem_rd_gnt) state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (mem_rd_rvalid) state_nxt = S_DECODE;
      S_DECODE:  state_nxt = (dec_error_type == 2'b01 || dec_error_type == 2'b10) ? S_WR_REQ : S_NEXT;
      S_WR_REQ:  if (mem_wr_gnt) state_nxt = S_NEXT;
      S_NEXT: begin
        if (!en)                state_nxt = S_IDLE;
        else if (INTERVAL == 0) state_nxt = S_RD_REQ;
        else                    state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!en)                          state_nxt = S_IDLE;
        else if (timer == TIMER_W'(1))    state_nxt = S_RD_REQ;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_req = (state == S_RD_REQ);
    mem_wr_req = (state == S_WR_REQ);
    busy       = (state != S_IDLE);
    pass_done  = (state == S_NEXT) && last_addr;
    state_dbg  = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      timer      <= '0;
      codeword_q <= '0;
      wr_data_q  <= '0;
      se_q       <= '0;
      dae_q      <= '0;
      ue_q       <= '0;
      ue_flag_q  <= 1'b0;
      ue_addr_q  <= '0;
    end else begin
      if (state == S_RD_WAIT && mem_rd_rvalid) codeword_q <= mem_rd_data;

      if (state == S_DECODE) begin
        case (dec_error_type)
          2'b01: begin
            if (se_q != CNT_MAX) se_q <= se_q + 1'b1;
            wr_data_q <= dec_message;
          end
          2'b10: begin
            if (dae_q != CNT_MAX) dae_q <= dae_q + 1'b1;
            wr_data_q <= dec_message;
          end
          2'b11: begin
            if (ue_q != CNT_MAX) ue_q <= ue_q + 1'b1;
            ue_addr_q <= addr;
          end
          default: ;
        endcase
      end

      // A fresh UE wins over a simultaneous clear so it is never lost.
      if (is_ue)         ue_flag_q <= 1'b1;
      else if (clear_ue) ue_flag_q <= 1'b0;

      if (state == S_NEXT) begin
        addr  <= last_addr ? '0 : addr + 1'b1;
        timer <= TIMER_LOAD;
      end else if (state == S_WAIT && timer != '0) begin
        timer <= timer - 1'b1;
      end
    end
  end

  assign mem_rd_addr  = addr;
  assign mem_wr_addr  = addr;
  assign mem_wr_data  = wr_data_q;
  assign dec_codeword = codeword_q;
  assign se_cnt       = se_q;
  assign dae_cnt      = dae_q;
  assign ue_cnt       = ue_q;
  assign ue_flag      = ue_flag_q;
  assign ue_addr      = ue_addr_q;

endmodule
